// File: rtl/signed_down_counter_pkg.sv
// Shared definitions for the signed down counter.
// Holds the FSM state encoding and the underflow-policy constants that
// the top module and the step sub-module both select on.
package signed_down_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_EXPIRED = 2'd2
  } state_e;

  localparam int MODE_SAT    = 0;  // hold at MIN and expire
  localparam int MODE_WRAP   = 1;  // MIN -> MAX
  localparam int MODE_RELOAD = 2;  // MIN -> stored load value

endpackage

// File: rtl/signed_down_counter_dec_step.sv
// signed_dec_step: combinational single decrement step.
// Ports:
//   value_i  - current signed count
//   reload_i - stored load value, used as the next value after MIN in reload mode
//   next_o   - count after one enabled step
//   at_min_o - value_i is MIN, so this step flags an underflow
module signed_dec_step
  import signed_down_counter_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int MODE  = MODE_SAT
) (
  input  logic signed [WIDTH-1:0] value_i,
  input  logic signed [WIDTH-1:0] reload_i,
  output logic signed [WIDTH-1:0] next_o,
  output logic                    at_min_o
);

  localparam logic signed [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  assign at_min_o = (value_i == MIN);

  // Subtraction is kept to WIDTH bits; the MIN case never reaches it.
  always_comb begin
    next_o = value_i - ONE;
    if (at_min_o) begin
      case (MODE)
        MODE_WRAP:   next_o = MAX;
        MODE_RELOAD: next_o = reload_i;
        default:     next_o = MIN;
      endcase
    end
  end

endmodule

// File: rtl/signed_down_counter.sv
// signed_down_counter: loadable two's-complement down counter / timer.
// Ports:
//   clk_i        - clock, all state changes on rising edge
//   reset_i      - synchronous active-low reset
//   load_i       - capture load_value_i into counter and reload register, go IDLE
//   load_value_i - signed start value
//   start_i      - IDLE -> COUNT (EXPIRED -> IDLE)
//   stop_i       - COUNT/EXPIRED -> IDLE, counter held
//   en_i         - decrement qualifier in COUNT
//   counter_o    - signed current count
//   busy_o       - state is COUNT
//   done_o       - state is EXPIRED (saturate mode only)
//   tc_o         - one-cycle pulse when an enabled step leaves MIN
module signed_down_counter
  import signed_down_counter_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int MODE  = MODE_SAT
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    load_i,
  input  logic signed [WIDTH-1:0] load_value_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic                    en_i,
  output logic signed [WIDTH-1:0] counter_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    tc_o
);

  state_e                  state_q;
  logic signed [WIDTH-1:0] counter_q, reload_q;
  logic                    busy_q, done_q, tc_q;

  logic signed [WIDTH-1:0] step_d;
  logic                    at_min;

  signed_dec_step #(.WIDTH(WIDTH), .MODE(MODE)) u_step (
    .value_i  (counter_q),
    .reload_i (reload_q),
    .next_o   (step_d),
    .at_min_o (at_min)
  );

  // busy/done are registered alongside every state transition so they
  // always mirror state_q without a decode stage.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q   <= ST_IDLE;
      counter_q <= '0;
      reload_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tc_q      <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (load_i) begin
        counter_q <= load_value_i;
        reload_q  <= load_value_i;
        state_q   <= ST_IDLE;
        busy_q    <= 1'b0;
        done_q    <= 1'b0;
      end else if (stop_i) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_i) begin
              state_q <= ST_COUNT;
              busy_q  <= 1'b1;
            end
          end
          ST_COUNT: begin
            // start has no effect in COUNT, so en still steps here.
            if (en_i) begin
              counter_q <= step_d;
              tc_q      <= at_min;
              if (at_min && MODE == MODE_SAT) begin
                state_q <= ST_EXPIRED;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
          ST_EXPIRED: begin
            if (start_i) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign counter_o = counter_q;
  assign busy_o    = busy_q;
  assign done_o    = (MODE == MODE_SAT) ? done_q : 1'b0;
  assign tc_o      = tc_q;

endmodule

// File: tb/tb_signed_down_counter.sv
// Directed bench: three instances (saturate, wrap, reload) share one
// stimulus stream; each scenario checks the instance whose policy it targets.
module tb_signed_down_counter;
  localparam int W = 5;

  logic clk = 1'b0;
  logic reset, load, start, stop, en;
  logic signed [W-1:0] lv;
  logic signed [W-1:0] cnt [3];
  logic busy [3], done [3], tc [3];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 3; m++) begin : g_dut
    signed_down_counter #(.WIDTH(W), .MODE(m)) dut (
      .clk_i(clk), .reset_i(reset), .load_i(load), .load_value_i(lv),
      .start_i(start), .stop_i(stop), .en_i(en),
      .counter_o(cnt[m]), .busy_o(busy[m]), .done_o(done[m]), .tc_o(tc[m])
    );
  end

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // one edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    load = 0; start = 0; stop = 0; en = 0; lv = '0;
  endtask

  initial begin
    reset = 0; idle_in();
    // 1. reset, then count from 0
    tick(); tick();
    for (int m = 0; m < 3; m++) begin
      chk("rst_cnt", int'(cnt[m]), 0);
      chk("rst_busy", int'(busy[m]), 0);
      chk("rst_done", int'(done[m]), 0);
      chk("rst_tc", int'(tc[m]), 0);
    end
    reset = 1; start = 1; en = 1;
    tick();
    chk("t1_start_cnt", int'(cnt[0]), 0);
    chk("t1_start_busy", int'(busy[0]), 1);
    start = 0;
    tick(); chk("t1_cnt_m1", int'(cnt[0]), -1);
    tick(); chk("t1_cnt_m2", int'(cnt[0]), -2);

    // 2. saturate: load 3, count to -16, expire
    idle_in(); load = 1; lv = 3; tick(); load = 0;
    chk("t2_load", int'(cnt[0]), 3);
    start = 1; tick(); start = 0; en = 1;
    chk("t2_busy", int'(busy[0]), 1);
    for (int k = 1; k <= 19; k++) begin
      tick();
      chk("t2_cnt", int'(cnt[0]), 3 - k);
      chk("t2_tc0", int'(tc[0]), 0);
    end
    tick();
    chk("t2_tc", int'(tc[0]), 1);
    chk("t2_min", int'(cnt[0]), -16);
    chk("t2_done", int'(done[0]), 1);
    chk("t2_busy0", int'(busy[0]), 0);
    chk("t2_done_wrap", int'(done[1]), 0);
    tick();
    chk("t2_tc_off", int'(tc[0]), 0);
    chk("t2_hold", int'(cnt[0]), -16);
    chk("t2_done_hold", int'(done[0]), 1);

    // 3. wrap: -15 -> -16 -> 15 (tc) -> 14
    idle_in(); load = 1; lv = -15; tick(); load = 0;
    start = 1; en = 1; tick(); start = 0;
    chk("t3_start", int'(cnt[1]), -15);
    tick(); chk("t3_min", int'(cnt[1]), -16);
    chk("t3_tc0", int'(tc[1]), 0);
    tick(); chk("t3_wrap", int'(cnt[1]), 15);
    chk("t3_tc", int'(tc[1]), 1);
    chk("t3_busy", int'(busy[1]), 1);
    tick(); chk("t3_14", int'(cnt[1]), 14);
    chk("t3_tc_off", int'(tc[1]), 0);
    chk("t3_busy2", int'(busy[1]), 1);

    // 4. reload: 2 .. -16, then back to 2, then load mid-run
    idle_in(); load = 1; lv = 2; tick(); load = 0;
    start = 1; tick(); start = 0; en = 1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      chk("t4_cnt", int'(cnt[2]), 2 - k);
    end
    tick();
    chk("t4_reload", int'(cnt[2]), 2);
    chk("t4_tc", int'(tc[2]), 1);
    chk("t4_busy", int'(busy[2]), 1);
    tick(); chk("t4_after", int'(cnt[2]), 1);
    load = 1; lv = 5; tick(); load = 0;
    chk("t4_ld_cnt", int'(cnt[2]), 5);
    chk("t4_ld_busy", int'(busy[2]), 0);
    tick(); chk("t4_idle_hold", int'(cnt[2]), 5);

    // reload with MIN: stuck at MIN, tc every enabled cycle
    idle_in(); load = 1; lv = -16; tick(); load = 0;
    start = 1; tick(); start = 0; en = 1;
    tick(); chk("t4m_cnt", int'(cnt[2]), -16); chk("t4m_tc", int'(tc[2]), 1);
    tick(); chk("t4m_cnt2", int'(cnt[2]), -16); chk("t4m_tc2", int'(tc[2]), 1);

    // 5. conflicts
    idle_in(); load = 1; start = 1; lv = 7; tick(); load = 0; start = 0;
    chk("t5_ls_cnt", int'(cnt[0]), 7);
    chk("t5_ls_busy", int'(busy[0]), 0);
    tick(); chk("t5_ls_idle", int'(busy[0]), 0);
    start = 1; tick(); start = 0;
    chk("t5_busy", int'(busy[0]), 1);
    stop = 1; en = 1; tick(); stop = 0; en = 0;
    chk("t5_stop_cnt", int'(cnt[0]), 7);
    chk("t5_stop_busy", int'(busy[0]), 0);
    chk("t5_stop_tc", int'(tc[0]), 0);

    // 6. en gating, then reset mid-count
    idle_in(); load = 1; lv = 4; tick(); load = 0;
    start = 1; tick(); start = 0;
    en = 1; tick(); chk("t6_e1", int'(cnt[0]), 3);
    en = 0; tick(); chk("t6_e0a", int'(cnt[0]), 3);
    tick(); chk("t6_e0b", int'(cnt[0]), 3);
    chk("t6_busy", int'(busy[0]), 1);
    en = 1; tick(); chk("t6_e1b", int'(cnt[0]), 2);
    for (int k = 0; k < 9; k++) tick();
    chk("t6_m7", int'(cnt[0]), -7);
    reset = 0; tick(); reset = 1; en = 0;
    chk("t6_rst_cnt", int'(cnt[0]), 0);
    chk("t6_rst_busy", int'(busy[0]), 0);
    chk("t6_rst_tc", int'(tc[0]), 0);
    chk("t6_rst_done", int'(done[0]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
